// File: rtl/piano_cmd_sequencer_if.sv
// Bus between the I/O decoder (master) and the piano command sequencer (slave).
// Latency: none; this interface is only a bundle of wires.
// Backpressure: none on the write side; the master polls oFull and oCount.
interface piano_cmd_sequencer_if #(
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          iQueueWrite;
  logic [15:0]   iWriteData;
  logic          iFlush;
  logic          oDoPianoWrite;
  logic [7:0]    oPianoDataToWrite;
  logic [CW-1:0] oCount;
  logic          oFull;
  logic          oEmpty;
  logic          oBusy;
  logic          oOverflow;

  modport master (
    output iQueueWrite, iWriteData, iFlush,
    input  oDoPianoWrite, oPianoDataToWrite, oCount, oFull, oEmpty, oBusy, oOverflow
  );

  modport slave (
    input  iQueueWrite, iWriteData, iFlush,
    output oDoPianoWrite, oPianoDataToWrite, oCount, oFull, oEmpty, oBusy, oOverflow
  );
endinterface

// File: rtl/piano_cmd_sequencer.sv
// Timed command queue: pops {duration, command} words and pulses each command to the piano driver.
// Latency: a write into an empty idle queue produces the write pulse two cycles after it is stored.
// Backpressure: none; writes while full are dropped and flagged on the sticky oOverflow.
module piano_cmd_sequencer #(
  parameter int DEPTH       = 16,
  parameter int TICK_CYCLES = 100000
) (
  input  logic                  iCpuClock,
  input  logic                  iCpuReset,
  piano_cmd_sequencer_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PW-1:0] TICK_LAST  = PW'(TICK_CYCLES - 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

  state_t        state;
  state_t        nextState;
  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] rdPtr;
  logic [AW-1:0] wrPtr;
  logic [CW-1:0] count;
  logic [PW-1:0] prescaler;
  logic [7:0]    remaining;
  logic          doWrite;
  logic [7:0]    dataOut;
  logic          overflow;
  logic          full;
  logic          empty;
  logic          pushEn;
  logic          popEn;
  logic          tickWrap;
  logic [15:0]   head;

  assign full     = (count == FULL_COUNT);
  assign empty    = (count == '0);
  assign head     = mem[rdPtr];
  // Flush wins over a same-cycle store, so the word is simply lost (not an overflow).
  assign pushEn   = bus.iQueueWrite && !full && !bus.iFlush;
  assign tickWrap = (prescaler == TICK_LAST);

  // State register.
  always_ff @(posedge iCpuClock or posedge iCpuReset) begin
    if (iCpuReset) state <= IDLE;
    else           state <= nextState;
  end

  // Next-state and pop decision; flush overrides everything and discards a pending issue.
  always_comb begin
    nextState = state;
    popEn     = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) nextState = ISSUE;
      end
      ISSUE: begin
        popEn     = 1'b1;
        nextState = (head[15:8] == 8'd0) ? IDLE : HOLD;
      end
      HOLD: begin
        if (tickWrap && (remaining == 8'd1)) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
    if (bus.iFlush) begin
      nextState = IDLE;
      popEn     = 1'b0;
    end
  end

  // Storage array; no reset needed because entries are only read once counted valid.
  always_ff @(posedge iCpuClock) begin
    if (pushEn) mem[wrPtr] <= bus.iWriteData;
  end

  // Circular pointers and explicit occupancy count.
  always_ff @(posedge iCpuClock or posedge iCpuReset) begin
    if (iCpuReset) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else if (bus.iFlush) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (pushEn) wrPtr <= wrPtr + 1'b1;
      if (popEn)  rdPtr <= rdPtr + 1'b1;
      case ({pushEn, popEn})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Hold timer: prescaler divides the clock into ticks, remaining counts ticks left.
  always_ff @(posedge iCpuClock or posedge iCpuReset) begin
    if (iCpuReset) begin
      prescaler <= '0;
      remaining <= '0;
    end else if (bus.iFlush) begin
      prescaler <= '0;
      remaining <= '0;
    end else if (popEn) begin
      prescaler <= '0;
      remaining <= head[15:8];
    end else if (state == HOLD) begin
      if (tickWrap) begin
        prescaler <= '0;
        remaining <= remaining - 8'd1;
      end else begin
        prescaler <= prescaler + 1'b1;
      end
    end
  end

  // Registered piano write: one pulse per issued entry, or a silence pulse on flush.
  always_ff @(posedge iCpuClock or posedge iCpuReset) begin
    if (iCpuReset) begin
      doWrite <= 1'b0;
      dataOut <= 8'h00;
    end else begin
      doWrite <= bus.iFlush || popEn;
      if (bus.iFlush)  dataOut <= 8'h00;
      else if (popEn)  dataOut <= head[7:0];
    end
  end

  // Sticky overflow: a store seen while full (judged before this edge's pop).
  always_ff @(posedge iCpuClock or posedge iCpuReset) begin
    if (iCpuReset)                         overflow <= 1'b0;
    else if (bus.iFlush)                   overflow <= 1'b0;
    else if (bus.iQueueWrite && full)      overflow <= 1'b1;
  end

  assign bus.oDoPianoWrite     = doWrite;
  assign bus.oPianoDataToWrite = dataOut;
  assign bus.oCount            = count;
  assign bus.oFull             = full;
  assign bus.oEmpty            = empty;
  assign bus.oBusy             = (state != IDLE);
  assign bus.oOverflow         = overflow;
endmodule

// File: tb/tb_piano_cmd_sequencer.sv
// Directed bench for the piano command sequencer with DEPTH=4 and TICK_CYCLES=4.
// Latency: inputs driven 1 time unit after each rising edge, outputs sampled at the same point.
// Backpressure: the bench never stalls; overflow behaviour is exercised directly.
module tb_piano_cmd_sequencer;
  logic clk;
  logic rst;
  int   nComp;
  int   nFail;

  piano_cmd_sequencer_if #(.DEPTH(4)) bus ();

  piano_cmd_sequencer #(.DEPTH(4), .TICK_CYCLES(4)) dut (
    .iCpuClock (clk),
    .iCpuReset (rst),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int observed, input int expected);
    nComp++;
    assert (observed === expected) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkReset(input string tag);
    check({tag, "_dpw"},   int'(bus.oDoPianoWrite), 0);
    check({tag, "_data"},  int'(bus.oPianoDataToWrite), 8'h00);
    check({tag, "_count"}, int'(bus.oCount), 0);
    check({tag, "_empty"}, int'(bus.oEmpty), 1);
    check({tag, "_full"},  int'(bus.oFull), 0);
    check({tag, "_busy"},  int'(bus.oBusy), 0);
    check({tag, "_ovf"},   int'(bus.oOverflow), 0);
  endtask

  initial begin
    int pulses;
    int busyCnt;
    int firstPulse;
    int maxCount;
    bit seenIdle;
    int pulseAt[$];
    int pulseData[$];

    nComp = 0;
    nFail = 0;
    rst = 1'b1;
    bus.iQueueWrite = 1'b0;
    bus.iWriteData  = 16'h0000;
    bus.iFlush      = 1'b0;

    // Reset state, then idle 10 cycles.
    #2;
    checkReset("rst");
    step();
    step();
    #3 rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.oDoPianoWrite) pulses++;
    end
    check("idle_pulses", pulses, 0);
    checkReset("idle");

    // Single entry 0x0312, plus a zero-duration 0x0034 queued during the hold.
    bus.iQueueWrite = 1'b1;
    bus.iWriteData  = 16'h0312;
    step();                                   // edge N
    bus.iQueueWrite = 1'b0;
    check("w1_count", int'(bus.oCount), 1);
    check("w1_busy",  int'(bus.oBusy), 0);
    check("w1_dpw",   int'(bus.oDoPianoWrite), 0);
    step();                                   // edge N+1: ISSUE
    check("w1_issue_busy", int'(bus.oBusy), 1);
    check("w1_issue_dpw",  int'(bus.oDoPianoWrite), 0);
    bus.iQueueWrite = 1'b1;
    bus.iWriteData  = 16'h0034;
    step();                                   // edge N+2: pulse, push+pop together
    bus.iQueueWrite = 1'b0;
    check("w1_pulse_dpw",  int'(bus.oDoPianoWrite), 1);
    check("w1_pulse_data", int'(bus.oPianoDataToWrite), 8'h12);
    check("pushpop_count", int'(bus.oCount), 1);
    busyCnt    = 2;
    seenIdle   = 1'b0;
    firstPulse = -1;
    pulses     = 0;
    for (int j = 3; j <= 20; j++) begin
      step();
      if (bus.oBusy && !seenIdle) busyCnt++;
      else if (!bus.oBusy) seenIdle = 1'b1;
      if (bus.oDoPianoWrite) begin
        pulses++;
        if (firstPulse < 0) firstPulse = j;
      end
    end
    check("w1_busy_cycles",  busyCnt, 13);
    check("w2_pulses",       pulses, 1);
    check("w2_pulse_offset", firstPulse, 16);
    check("w2_data",         int'(bus.oPianoDataToWrite), 8'h34);
    check("w2_count",        int'(bus.oCount), 0);
    check("w2_busy",         int'(bus.oBusy), 0);

    // Three zero-duration entries back-to-back.
    maxCount = 0;
    pulseAt.delete();
    pulseData.delete();
    for (int j = 0; j < 12; j++) begin
      bus.iQueueWrite = (j < 3);
      bus.iWriteData  = 16'h0001 + 16'(j);
      step();
      if (bus.oDoPianoWrite) begin
        pulseAt.push_back(j);
        pulseData.push_back(int'(bus.oPianoDataToWrite));
      end
      if (int'(bus.oCount) > maxCount) maxCount = int'(bus.oCount);
    end
    bus.iQueueWrite = 1'b0;
    check("b2b_npulses", pulseAt.size(), 3);
    if (pulseAt.size() == 3) begin
      check("b2b_t0", pulseAt[0], 2);
      check("b2b_t1", pulseAt[1], 4);
      check("b2b_t2", pulseAt[2], 6);
      check("b2b_d0", pulseData[0], 8'h01);
      check("b2b_d1", pulseData[1], 8'h02);
      check("b2b_d2", pulseData[2], 8'h03);
    end
    check("b2b_maxcount", maxCount, 2);
    check("b2b_endcount", int'(bus.oCount), 0);

    // Long hold (0xFF ticks) while six more words arrive: four fit, two overflow.
    bus.iQueueWrite = 1'b1;
    bus.iWriteData  = 16'hFF41;
    step();
    bus.iQueueWrite = 1'b0;
    step();
    step();
    check("ovf_first_pulse", int'(bus.oPianoDataToWrite), 8'h41);
    for (int j = 0; j < 6; j++) begin
      bus.iQueueWrite = 1'b1;
      bus.iWriteData  = 16'h0051 + 16'(j);
      step();
      if (j == 3) begin
        check("ovf_full_at4",  int'(bus.oFull), 1);
        check("ovf_clear_at4", int'(bus.oOverflow), 0);
      end
    end
    bus.iQueueWrite = 1'b0;
    check("ovf_count", int'(bus.oCount), 4);
    check("ovf_full",  int'(bus.oFull), 1);
    check("ovf_flag",  int'(bus.oOverflow), 1);
    pulseData.delete();
    for (int j = 0; j < 1100; j++) begin
      step();
      if (bus.oDoPianoWrite) pulseData.push_back(int'(bus.oPianoDataToWrite));
    end
    check("ovf_npulses", pulseData.size(), 4);
    if (pulseData.size() == 4) begin
      for (int k = 0; k < 4; k++) check("ovf_data", pulseData[k], 8'h51 + k);
    end
    check("ovf_sticky", int'(bus.oOverflow), 1);
    check("ovf_empty",  int'(bus.oEmpty), 1);

    // Flush during the hold of a duration-5 entry with two queued, plus a same-cycle store.
    bus.iQueueWrite = 1'b1;
    bus.iWriteData  = 16'h0561;
    step();
    bus.iQueueWrite = 1'b0;
    step();
    step();
    check("fl_pulse_data", int'(bus.oPianoDataToWrite), 8'h61);
    bus.iQueueWrite = 1'b1;
    bus.iWriteData  = 16'h0062;
    step();
    bus.iWriteData  = 16'h0063;
    step();
    bus.iQueueWrite = 1'b0;
    step();
    check("fl_pre_count", int'(bus.oCount), 2);
    check("fl_pre_busy",  int'(bus.oBusy), 1);
    bus.iFlush      = 1'b1;
    bus.iQueueWrite = 1'b1;
    bus.iWriteData  = 16'h0077;
    step();
    bus.iFlush      = 1'b0;
    bus.iQueueWrite = 1'b0;
    check("fl_dpw",   int'(bus.oDoPianoWrite), 1);
    check("fl_data",  int'(bus.oPianoDataToWrite), 8'h00);
    check("fl_count", int'(bus.oCount), 0);
    check("fl_ovf",   int'(bus.oOverflow), 0);
    check("fl_busy",  int'(bus.oBusy), 0);
    pulses = 0;
    for (int j = 0; j < 30; j++) begin
      step();
      if (bus.oDoPianoWrite) pulses++;
    end
    check("fl_after_pulses", pulses, 0);

    // Asynchronous reset in the middle of a hold.
    bus.iQueueWrite = 1'b1;
    bus.iWriteData  = 16'h0371;
    step();
    bus.iWriteData  = 16'h0072;
    step();
    bus.iQueueWrite = 1'b0;
    step();
    step();
    check("ar_pre_busy", int'(bus.oBusy), 1);
    check("ar_pre_data", int'(bus.oPianoDataToWrite), 8'h71);
    #3 rst = 1'b1;
    #1;
    checkReset("ar");
    #2 rst = 1'b0;
    pulses = 0;
    for (int j = 0; j < 20; j++) begin
      step();
      if (bus.oDoPianoWrite) pulses++;
    end
    check("ar_after_pulses", pulses, 0);
    check("ar_after_empty",  int'(bus.oEmpty), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nComp, nFail);
    $finish;
  end
endmodule

// File: doc/piano_cmd_sequencer.md
Name: piano_cmd_sequencer

Overview:
- Timed command queue between the memory-mapped I/O decoder and the piano driver.
- The CPU stores {duration, command} words into a FIFO.
- The sequencer pops one word at a time and issues the 8-bit command to the piano driver as a one-cycle write pulse. It then holds for the stored duration before issuing the next word.
- The CPU can queue a whole melody with back-to-back stores and poll status instead of busy-wait timing loops.

Parameters:
- DEPTH, 16, FIFO entries; must be a power of 2, minimum 2.
- TICK_CYCLES, 100000, iCpuClock cycles per duration tick; minimum 1.

Ports:
- iCpuClock  in  1  CPU clock; all state changes on its rising edge.
- iCpuReset  in  1  asynchronous, active-high reset.
- iQueueWrite  in  1  enqueue strobe from the I/O decoder (chip select AND store), one word per cycle high.
- iWriteData  in  16  [7:0] piano command, [15:8] duration in ticks.
- iFlush  in  1  discard queue, abort hold, emit silence.
- oDoPianoWrite  out  1  one-cycle pulse to the piano driver write input.
- oPianoDataToWrite  out  8  command accompanying oDoPianoWrite.
- oCount  out  log2(DEPTH)+1  number of queued entries.
- oFull  out  1  oCount==DEPTH.
- oEmpty  out  1  oCount==0.
- oBusy  out  1  FSM not in IDLE.
- oOverflow  out  1  sticky: a write was dropped.

Behaviour:
- Reset: iCpuReset is asynchronous and active-high; clock is iCpuClock. While reset is high:
  - FIFO pointers and count = 0; FSM = IDLE; prescaler and duration counter = 0.
  - oDoPianoWrite=0, oPianoDataToWrite=8'h00, oOverflow=0, oEmpty=1, oFull=0, oBusy=0.
  - Reset mid-hold aborts silently; no silence pulse is emitted.
- FIFO:
  - Circular buffer with wrap-around read/write pointers; oCount is tracked explicitly.
  - Write accepted when iQueueWrite=1, oFull=0 and iFlush=0.
  - Write while full is dropped and sets oOverflow=1. This holds even if a pop happens the same cycle; full status is evaluated before the edge.
  - A pop and an accepted write in the same cycle leave oCount unchanged.
- FSM states:
  - IDLE: if !oEmpty, go to ISSUE next edge.
  - ISSUE (one cycle):
    - Register oDoPianoWrite=1 and oPianoDataToWrite=head[7:0] for the following cycle.
    - Pop the head; load remaining=head[15:8]; clear the prescaler.
    - If head[15:8]==0, go to IDLE; otherwise go to HOLD.
  - HOLD:
    - Prescaler counts 0..TICK_CYCLES-1; on wrap, remaining decrements.
    - When remaining reaches 0, go to IDLE.
    - Hold length is exactly duration*TICK_CYCLES cycles, measured from the ISSUE edge.
- Outputs and latency:
  - Outputs are registered. oDoPianoWrite is high for exactly one cycle per issued entry.
  - oPianoDataToWrite holds its last value between pulses.
  - Latency: a write at edge N into an empty queue in IDLE gives FSM=ISSUE at edge N+1 and oDoPianoWrite=1 during cycle N+2.
  - Zero-duration entries issue every 2 cycles.
- Flush:
  - iFlush=1 at an edge clears the FIFO and oOverflow, forces IDLE, and emits one pulse with oPianoDataToWrite=8'h00 (silence).
  - Flush beats a same-cycle write (write dropped, no overflow) and beats a same-cycle ISSUE (entry is discarded, not issued).
- oBusy=1 in ISSUE and HOLD.

Test Plan:
- Bench configuration: DEPTH=4, TICK_CYCLES=4.
- Reset then idle 10 cycles -> oEmpty=1, oCount=0, oBusy=0, no oDoPianoWrite pulse, oPianoDataToWrite=8'h00.
- Write 16'h0312 at edge N -> pulse with data 8'h12 during cycle N+2 only; oBusy high for 1+12 cycles; second pulse only after FSM returns to IDLE.
- Write 16'h0001, 16'h0002, 16'h0003 back-to-back -> pulses carry 01, 02, 03 spaced exactly 2 cycles apart; oCount peaks at 2 or 3 per timing and returns to 0.
- Write 6 words while the first is held (duration 8'hFF) -> oCount=4, oFull=1, oOverflow=1; words 5–6 are never issued.
- During HOLD of a duration-5 entry with 2 queued, assert iFlush -> next cycle single pulse data 8'h00; oCount=0, oOverflow=0, oBusy=0; no further pulses.
- Assert iCpuReset asynchronously mid-HOLD (between clock edges) -> outputs return to reset values immediately; after release, queue is empty and no pulse is emitted.
